// File: rtl/mmio_pkg.sv
// mmio_pkg: register map, status bit positions and default I/O window base for mmio_responder.
package mmio_pkg;
  typedef enum logic [1:0] {
    REG_SWITCH  = 2'd0,
    REG_COUNT   = 2'd1,
    REG_COMPARE = 2'd2,
    REG_STATUS  = 2'd3
  } mmio_reg_t;
  localparam int STAT_FLAG = 0;
  localparam int STAT_EN   = 1;
  localparam logic [15:0] IO_BASE = 16'h2000;
endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: interval timer with count/compare/enable and a sticky match flag cleared by W1C.
module mmio_timer import mmio_pkg::*; (
  input  logic        clock,
  input  logic        reset,
  input  logic        cnt_load,
  input  logic        cmp_load,
  input  logic        stat_load,
  input  logic [15:0] wdata,
  output logic [15:0] count,
  output logic [15:0] compare,
  output logic        enable,
  output logic        flag
);
  logic match;
  assign match = count == compare;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count   <= '0;
      compare <= 16'hFFFF;
      enable  <= 1'b0;
      flag    <= 1'b0;
    end else begin
      count <= cnt_load ? wdata : enable ? (match ? '0 : count + 16'd1) : count;
      if (cmp_load) compare <= wdata;
      if (stat_load) enable <= wdata[STAT_EN];
      // a match in the same cycle as a W1C keeps the flag set
      flag <= (enable & match) | (flag & ~(stat_load & wdata[STAT_FLAG]));
    end
  end
endmodule

// File: rtl/tridrive.sv
// tridrive: drives a shared bus with data while en is high, otherwise releases it to high-Z.
module tridrive #(
  parameter int W = 16
) (
  input  logic [W-1:0] data,
  input  logic         en,
  inout  wire  [W-1:0] bus
);
  assign bus = en ? data : {W{1'bz}};
endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: 4-word I/O window (switches/LEDs, interval timer) on the p18240 memory bus.
// Optional switch debounce when SW_DEBOUNCE_EN is defined.
module mmio_responder import mmio_pkg::*; #(
  parameter logic [15:0] BASE_ADDR       = IO_BASE,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] memAddr,
  inout  wire  [15:0] dataBus,
  input  logic        re_L,
  input  logic        we_L,
  input  logic [15:0] SW,
  output logic [15:0] LEDR,
  output logic        timerFlag
);
  logic        hit, wr, rd_en;
  mmio_reg_t   offset;
  logic [15:0] sw_s1, sw_s2, sw_val, rd_data, count, compare;
  logic        enable, flag;
  assign hit    = memAddr[15:2] == BASE_ADDR[15:2];
  assign offset = mmio_reg_t'(memAddr[1:0]);
  assign wr     = hit & ~we_L;
  // reset gates the drive so an in-flight read releases the bus at once
  assign rd_en  = hit & ~re_L & we_L & ~reset;
  assign timerFlag = flag;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      LEDR  <= '0;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
      if (wr && offset == REG_SWITCH) LEDR <= dataBus;
    end
  end
`ifdef SW_DEBOUNCE_EN
  logic [15:0] deb, deb_cnt;
  // the counter restarts whenever the synchronized value is about to change or already matches
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb     <= '0;
      deb_cnt <= DEBOUNCE_CYCLES - 16'd1;
    end else if (sw_s1 != sw_s2 || sw_s2 == deb) begin
      deb_cnt <= DEBOUNCE_CYCLES - 16'd1;
    end else if (deb_cnt == '0) begin
      deb <= sw_s2;
    end else begin
      deb_cnt <= deb_cnt - 16'd1;
    end
  end
  assign sw_val = deb;
`else
  assign sw_val = sw_s2;
`endif
  mmio_timer u_timer (
    .clock     (clock),
    .reset     (reset),
    .cnt_load  (wr && offset == REG_COUNT),
    .cmp_load  (wr && offset == REG_COMPARE),
    .stat_load (wr && offset == REG_STATUS),
    .wdata     (dataBus),
    .count     (count),
    .compare   (compare),
    .enable    (enable),
    .flag      (flag)
  );
  always_comb begin
    rd_data = offset == REG_SWITCH  ? sw_val :
              offset == REG_COUNT   ? count :
              offset == REG_COMPARE ? compare : {14'b0, enable, flag};
  end
  tridrive #(.W(16)) u_drive (
    .data (rd_data),
    .en   (rd_en),
    .bus  (dataBus)
  );
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed checks of decode, LED latch, timer timing, W1C race and async reset.
module tb_mmio_responder;
  logic        clock = 1'b0, reset = 1'b1, re_l = 1'b1, we_l = 1'b1, drv = 1'b0;
  logic [15:0] mem_addr = '0, wdata = '0, sw = 16'hA5A5, rd;
  logic [15:0] ledr;
  logic        timer_flag;
  wire  [15:0] data_bus;
  int checks = 0, errors = 0;
  // an idle bus floats high, so a released bus reads 16'hFFFF
  pullup (data_bus[0]);  pullup (data_bus[1]);  pullup (data_bus[2]);  pullup (data_bus[3]);
  pullup (data_bus[4]);  pullup (data_bus[5]);  pullup (data_bus[6]);  pullup (data_bus[7]);
  pullup (data_bus[8]);  pullup (data_bus[9]);  pullup (data_bus[10]); pullup (data_bus[11]);
  pullup (data_bus[12]); pullup (data_bus[13]); pullup (data_bus[14]); pullup (data_bus[15]);
  assign data_bus = drv ? wdata : 16'bz;
  always #5 clock = ~clock;
  mmio_responder dut (
    .clock     (clock),
    .reset     (reset),
    .memAddr   (mem_addr),
    .dataBus   (data_bus),
    .re_L      (re_l),
    .we_L      (we_l),
    .SW        (sw),
    .LEDR      (ledr),
    .timerFlag (timer_flag)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clock);
    mem_addr = addr; wdata = data; drv = 1'b1; we_l = 1'b0;
    @(posedge clock);
    #1 we_l = 1'b1; drv = 1'b0;
  endtask
  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
    @(negedge clock);
    mem_addr = addr; re_l = 1'b0;
    #1 data = data_bus;
    @(posedge clock);
    #1 re_l = 1'b1;
  endtask
  initial begin
    repeat (3) @(posedge clock);
    #1 check("reset_ledr", ledr, 16'h0);
    check("reset_flag", {15'b0, timer_flag}, 16'h0);
    check("reset_bus_idle", data_bus, 16'hFFFF);
    @(negedge clock) reset = 1'b0;
    repeat (3) @(posedge clock);
    bus_read(16'h2000, rd); check("read_switch", rd, 16'hA5A5);
    bus_read(16'h2004, rd); check("read_miss", rd, 16'hFFFF);
    bus_read(16'h2001, rd); check("reset_count", rd, 16'h0000);
    bus_read(16'h2003, rd); check("reset_status", rd, 16'h0000);
    bus_write(16'h2000, 16'h1234); check("led_write", ledr, 16'h1234);
    bus_read(16'h2000, rd); check("switch_not_led", rd, 16'hA5A5);
    bus_write(16'h2004, 16'hBEEF); check("miss_write", ledr, 16'h1234);
    // period of compare+1: flag rises on the 5th edge after enabling
    bus_write(16'h2002, 16'h0004);
    bus_read(16'h2002, rd); check("read_compare", rd, 16'h0004);
    bus_write(16'h2003, 16'h0002);
    check("flag_after_enable", {15'b0, timer_flag}, 16'h0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock);
      #1 check($sformatf("flag_edge%0d", k), {15'b0, timer_flag}, k == 5 ? 16'h1 : 16'h0);
    end
    bus_read(16'h2001, rd); check("count_after_match", rd, 16'h0000);
    bus_write(16'h2003, 16'h0003); check("w1c_clear", {15'b0, timer_flag}, 16'h0);
    bus_read(16'h2003, rd); check("status_enable_kept", rd, 16'h0002);
    // W1C coinciding with a match: the set wins
    bus_write(16'h2003, 16'h0000);
    bus_write(16'h2001, 16'h0000);
    bus_write(16'h2002, 16'h0003);
    bus_write(16'h2003, 16'h0002);
    repeat (4) @(posedge clock);
    #1 check("match_cmp3", {15'b0, timer_flag}, 16'h1);
    bus_write(16'h2003, 16'h0003); check("w1c_no_match", {15'b0, timer_flag}, 16'h0);
    repeat (2) @(posedge clock);
    bus_write(16'h2003, 16'h0003); check("w1c_vs_match", {15'b0, timer_flag}, 16'h1);
    bus_read(16'h2003, rd); check("status_after_race", rd, 16'h0003);
    // wrap from 16'hFFFF to 0
    bus_write(16'h2002, 16'h0005);
    bus_write(16'h2001, 16'hFFFF);
    bus_read(16'h2001, rd); check("count_loaded", rd, 16'hFFFF);
    bus_read(16'h2001, rd); check("count_wrapped", rd, 16'h0000);
    // async reset during an active read
    @(negedge clock);
    mem_addr = 16'h2000; re_l = 1'b0;
    #1 check("read_before_reset", data_bus, 16'hA5A5);
    #1 reset = 1'b1;
    #1 check("bus_released_on_reset", data_bus, 16'hFFFF);
    check("ledr_reset", ledr, 16'h0);
    check("flag_reset", {15'b0, timer_flag}, 16'h0);
    re_l = 1'b1;
    @(negedge clock) reset = 1'b0;
    bus_read(16'h2000, rd); check("sync_reset", rd, 16'h0000);
    bus_read(16'h2003, rd); check("status_reset", rd, 16'h0000);
    bus_read(16'h2001, rd); check("count_reset", rd, 16'h0000);
    bus_read(16'h2002, rd); check("compare_reset", rd, 16'hFFFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
